// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel input conditioner.
// Each channel is synchronised through a STAGES-deep flop chain and then
// debounced. The filtered level only changes after the synchronised input
// has disagreed with it for FILTER_CYCLES+1 consecutive cycles. Level changes
// raise one-cycle rise/fall pulses and set bits in a sticky event mask that
// a consumer clears with evt_valid/evt_ready.

module sync_debounce #(
    parameter int               WIDTH         = 4,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask
);

    // Counter must hold the value FILTER_CYCLES; keep at least one bit so
    // the FILTER_CYCLES=0 configuration still has a legal vector.
    localparam int CNT_W = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

    // Synchroniser chain, index 0 is the first flop after the async input.
    logic [WIDTH-1:0] sync_r [STAGES];

    // Debounce state.
    logic [CNT_W-1:0] cnt_r     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] filt_r;
    logic [WIDTH-1:0] filt_nxt_s;
    logic [WIDTH-1:0] change_s;

    // Edge pulses and event handshake state.
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] mask_nxt_s;
    logic             valid_r;
    logic             ack_s;

    // Shift each channel through the synchroniser; reset loads the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_r[s] <= RESET_VALUE;
            end
        end else begin
            sync_r[0] <= async_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_out = sync_r[STAGES-1];

    // Per-channel run-length of disagreement; a matching cycle drops any
    // partial glitch, and a full run commits the new level.
    always_comb begin
        change_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_out[i] == filt_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_MAX) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
                change_s[i]  = 1'b1;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // A committed change simply flips the filtered bit.
    assign filt_nxt_s = filt_r ^ change_s;

    // Acknowledge drops the old mask, but changes landing on the same edge
    // are OR-ed in afterwards so they are never lost.
    always_comb begin
        ack_s = valid_r & evt_ready;
        if (ack_s) begin
            mask_nxt_s = change_s;
        end else begin
            mask_nxt_s = mask_r | change_s;
        end
    end

    // Debounce counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Filtered level, edge pulses and event mask all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_r  <= RESET_VALUE;
            rise_r  <= {WIDTH{1'b0}};
            fall_r  <= {WIDTH{1'b0}};
            mask_r  <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else begin
            filt_r  <= filt_nxt_s;
            rise_r  <= change_s & filt_nxt_s;
            fall_r  <= change_s & ~filt_nxt_s;
            mask_r  <= mask_nxt_s;
            valid_r <= |mask_nxt_s;
        end
    end

    assign filt_out  = filt_r;
    assign rise      = rise_r;
    assign fall      = fall_r;
    assign evt_mask  = mask_r;
    assign evt_valid = valid_r;

endmodule

// File: tb/tb_sync_debounce.sv
// Testbench for sync_debounce: directed scenarios plus randomized traffic
// checked against a window-based behavioural model of the main instance.

module tb_sync_debounce;

    localparam int F = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] async_in;
    logic [3:0] sync_out, filt_out, rise, fall, evt_mask;
    logic       evt_valid, evt_ready;

    logic [3:0] f0_async, f0_sync, f0_filt, f0_rise, f0_fall, f0_mask;
    logic       f0_valid;
    logic       f0_ready = 1'b0;

    logic [3:0] rv_async, rv_sync, rv_filt, rv_rise, rv_fall, rv_mask;
    logic       rv_valid;
    logic       rv_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the main instance.
    logic [3:0] m_p0 = 4'b0000, m_p1 = 4'b0000;
    logic [3:0] m_filt = 4'b0000, m_rise = 4'b0000, m_fall = 4'b0000, m_mask = 4'b0000;
    logic [3:0] m_hist[$];

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b0000)) dut (
        .clk(clk), .reset(reset), .async_in(async_in), .sync_out(sync_out),
        .filt_out(filt_out), .rise(rise), .fall(fall), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_mask(evt_mask));

    sync_debounce #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(4'b0000)) dut_f0 (
        .clk(clk), .reset(reset), .async_in(f0_async), .sync_out(f0_sync),
        .filt_out(f0_filt), .rise(f0_rise), .fall(f0_fall), .evt_valid(f0_valid),
        .evt_ready(f0_ready), .evt_mask(f0_mask));

    sync_debounce #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b1111)) dut_rv (
        .clk(clk), .reset(reset), .async_in(rv_async), .sync_out(rv_sync),
        .filt_out(rv_filt), .rise(rv_rise), .fall(rv_fall), .evt_valid(rv_valid),
        .evt_ready(rv_ready), .evt_mask(rv_mask));

    // Advance one clock and update the model: a channel flips once its last
    // F+1 synchronised samples all disagree with the current filtered level.
    task automatic cycle();
        logic [3:0] smp, chg, newf;
        bit all_diff;
        @(posedge clk);
        if (reset) begin
            m_p0 = 4'b0000; m_p1 = 4'b0000; m_filt = 4'b0000;
            m_rise = 4'b0000; m_fall = 4'b0000; m_mask = 4'b0000;
            m_hist.delete();
        end else begin
            smp = m_p1;
            m_hist.push_back(smp);
            if (m_hist.size() > F + 1) void'(m_hist.pop_front());
            chg = 4'b0000;
            for (int ch = 0; ch < 4; ch++) begin
                if (m_hist.size() == F + 1) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][ch] == m_filt[ch]) all_diff = 1'b0;
                    chg[ch] = all_diff;
                end
            end
            m_mask = (((m_mask != 4'b0000) && evt_ready) ? 4'b0000 : m_mask) | chg;
            newf   = m_filt ^ chg;
            m_rise = chg & newf;
            m_fall = chg & ~newf;
            m_filt = newf;
            m_p1   = m_p0;
            m_p0   = async_in;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({sync_out, filt_out, rise, fall, evt_mask, evt_valid} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_main: got %h exp 0", {sync_out, filt_out, rise, fall, evt_mask, evt_valid});
        end
        n_cmp++;
        if (rv_filt !== 4'b1111 || rv_sync !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_value_inst: got filt=%b sync=%b exp 1111/1111", rv_filt, rv_sync);
        end
        reset = 1'b0;
    endtask

    task automatic test_rise();
        async_in = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            n_cmp++;
            if (sync_out !== ((e >= 2) ? 4'b0001 : 4'b0000)) begin
                n_err++;
                $display("FAIL rise_sync e%0d: got %b", e, sync_out);
            end
            n_cmp++;
            if ({filt_out, rise, evt_mask, evt_valid} !==
                {((e >= 6) ? 4'b0001 : 4'b0000), ((e == 6) ? 4'b0001 : 4'b0000),
                 ((e >= 6) ? 4'b0001 : 4'b0000), (e >= 6)}) begin
                n_err++;
                $display("FAIL rise_filt e%0d: got filt=%b rise=%b mask=%b valid=%b", e, filt_out, rise, evt_mask, evt_valid);
            end
        end
    endtask

    task automatic test_glitch();
        evt_ready = 1'b1;
        cycle();
        evt_ready = 1'b0;
        n_cmp++;
        if (evt_mask !== 4'b0000 || evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_ack: got mask=%b valid=%b exp 0000/0", evt_mask, evt_valid);
        end
        async_in = 4'b0011;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (e == 3) async_in = 4'b0001;
            n_cmp++;
            if (sync_out !== ((e >= 2 && e <= 4) ? 4'b0011 : 4'b0001)) begin
                n_err++;
                $display("FAIL glitch_sync e%0d: got %b", e, sync_out);
            end
            n_cmp++;
            if ({filt_out, rise, fall, evt_mask} !== {4'b0001, 4'b0000, 4'b0000, 4'b0000}) begin
                n_err++;
                $display("FAIL glitch_filt e%0d: got filt=%b rise=%b fall=%b mask=%b", e, filt_out, rise, fall, evt_mask);
            end
        end
    endtask

    task automatic test_ack_collision();
        reset = 1'b1; async_in = 4'b0000;
        cycle();
        reset = 1'b0;
        async_in = 4'b0001;
        for (int e = 1; e <= 6; e++) cycle();
        n_cmp++;
        if (evt_mask !== 4'b0001) begin
            n_err++;
            $display("FAIL ack_setup: got mask=%b exp 0001", evt_mask);
        end
        async_in = 4'b0101;
        for (int e = 1; e <= 6; e++) begin
            evt_ready = (e == 6);
            cycle();
            n_cmp++;
            if ({evt_mask, evt_valid} !== {((e == 6) ? 4'b0100 : 4'b0001), 1'b1}) begin
                n_err++;
                $display("FAIL ack_collision e%0d: got mask=%b valid=%b", e, evt_mask, evt_valid);
            end
        end
        evt_ready = 1'b0;
        n_cmp++;
        if (rise !== 4'b0100 || filt_out !== 4'b0101) begin
            n_err++;
            $display("FAIL ack_rise: got rise=%b filt=%b exp 0100/0101", rise, filt_out);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; async_in = 4'b0000;
        cycle();
        reset = 1'b0;
        async_in = 4'b1000;
        for (int e = 1; e <= 4; e++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_cmp++;
        if ({sync_out, filt_out, rise, fall, evt_mask} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_mid_state: got %h exp 0", {sync_out, filt_out, rise, fall, evt_mask});
        end
        for (int r = 1; r <= 8; r++) begin
            cycle();
            n_cmp++;
            if ({filt_out, rise, fall} !== {((r >= 6) ? 4'b1000 : 4'b0000), ((r == 6) ? 4'b1000 : 4'b0000), 4'b0000}) begin
                n_err++;
                $display("FAIL reset_mid_r%0d: got filt=%b rise=%b fall=%b", r, filt_out, rise, fall);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1; async_in = 4'b0000;
        cycle();
        reset = 1'b0;
        async_in = 4'b1111;
        for (int e = 1; e <= 14; e++) begin
            if (e == 7) async_in = 4'b0000;
            evt_ready = (e == 13);
            cycle();
            n_cmp++;
            if ({sync_out, filt_out, rise, fall, evt_mask, evt_valid} !==
                {m_p1, m_filt, m_rise, m_fall, m_mask, (m_mask != 4'b0000)}) begin
                n_err++;
                $display("FAIL b2b_model e%0d: got %h exp %h", e,
                         {sync_out, filt_out, rise, fall, evt_mask, evt_valid},
                         {m_p1, m_filt, m_rise, m_fall, m_mask, (m_mask != 4'b0000)});
            end
            if (e == 6) begin
                n_cmp++;
                if (evt_mask !== 4'b1111 || rise !== 4'b1111) begin
                    n_err++;
                    $display("FAIL b2b_all: got mask=%b rise=%b exp 1111/1111", evt_mask, rise);
                end
            end
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_filter0();
        reset = 1'b1; f0_async = 4'b0000;
        cycle();
        reset = 1'b0;
        f0_async = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            cycle();
            if (e == 3) f0_async = 4'b0000;
            if (e == 4) f0_async = 4'b0001;
            n_cmp++;
            if ({f0_filt, f0_rise, f0_fall} !==
                {((e >= 3 && e != 6) ? 4'b0001 : 4'b0000),
                 ((e == 3 || e == 7) ? 4'b0001 : 4'b0000),
                 ((e == 6) ? 4'b0001 : 4'b0000)}) begin
                n_err++;
                $display("FAIL filter0 e%0d: got filt=%b rise=%b fall=%b", e, f0_filt, f0_rise, f0_fall);
            end
        end
    endtask

    task automatic test_reset_value();
        rv_async = 4'b1111;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            cycle();
            n_cmp++;
            if ({rv_filt, rv_rise, rv_fall, rv_valid} !== {4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL rv_idle e%0d: got filt=%b rise=%b fall=%b valid=%b", e, rv_filt, rv_rise, rv_fall, rv_valid);
            end
        end
        rv_async = 4'b1011;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            n_cmp++;
            if ({rv_filt, rv_fall, rv_rise} !==
                {((e >= 6) ? 4'b1011 : 4'b1111), ((e == 6) ? 4'b0100 : 4'b0000), 4'b0000}) begin
                n_err++;
                $display("FAIL rv_fall e%0d: got filt=%b fall=%b rise=%b", e, rv_filt, rv_fall, rv_rise);
            end
        end
    endtask

    task automatic test_random();
        int hold[4];
        for (int ch = 0; ch < 4; ch++) hold[ch] = $urandom_range(1, 7);
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 79) == 0);
            evt_ready = ($urandom_range(0, 3) == 0);
            for (int ch = 0; ch < 4; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    async_in[ch] = ~async_in[ch];
                    hold[ch] = $urandom_range(1, 7);
                end
            end
            cycle();
            n_cmp++;
            if ({sync_out, filt_out, rise, fall, evt_mask, evt_valid} !==
                {m_p1, m_filt, m_rise, m_fall, m_mask, (m_mask != 4'b0000)}) begin
                n_err++;
                $display("FAIL random c%0d: got %h exp %h", c,
                         {sync_out, filt_out, rise, fall, evt_mask, evt_valid},
                         {m_p1, m_filt, m_rise, m_fall, m_mask, (m_mask != 4'b0000)});
            end
        end
        reset = 1'b0;
        evt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        async_in  = 4'b0000;
        evt_ready = 1'b0;
        f0_async  = 4'b0000;
        rv_async  = 4'b1111;
        test_reset();
        test_rise();
        test_glitch();
        test_ack_collision();
        test_reset_mid();
        test_back_to_back();
        test_filter0();
        test_reset_value();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
